// File: rtl/jt51_sh_pkg.sv
// Shared types and constants for the shift-ring read-back tap.
package jt51_sh_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, VALID} sh_state_t;

    // WAIT gives up after this many full rotations' worth of cen pulses
    localparam int TOUT_MUL = 2;

    function automatic int sh_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jt51_slot_cnt.sv
// Tracks which ring slot is leaving the ring on each cen cycle; sync pins slot 0.
module jt51_slot_cnt
    import jt51_sh_pkg::*;
#(
    parameter  int stages = 32,
    localparam int SW     = sh_idx_w(stages)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          sync,
    output logic [SW-1:0] cnt_now,
    output logic          locked
);

    logic [SW-1:0] cnt;

    // sync always wins, so a misaligned counter silently snaps back to slot 0
    assign cnt_now = sync ? '0 : cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            locked <= 1'b0;
        end else if (cen) begin
            cnt <= (cnt_now == SW'(stages - 1)) ? '0 : cnt_now + 1'b1;
            if (sync) locked <= 1'b1;
        end
    end

endmodule

// File: rtl/jt51_sh_peek.sv
// Read-back tap: captures the ring output when the requested slot passes.
module jt51_sh_peek
    import jt51_sh_pkg::*;
#(
    parameter  int width  = 5,
    parameter  int stages = 32,
    localparam int SW     = sh_idx_w(stages)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [width-1:0] ring_dout,
    input  logic             sync,
    input  logic             req,
    input  logic [SW-1:0]    req_slot,
    output logic             rd_ready,
    output logic             rd_valid,
    output logic [width-1:0] rd_data,
    output logic             rd_err,
    input  logic             rd_ack
);

    localparam int TOUT = TOUT_MUL * stages;
    localparam int TW   = $clog2(TOUT + 1);

    sh_state_t     state, state_nx;
    logic [SW-1:0] slot, cnt_now;
    logic [TW-1:0] tcnt, tcnt_inc;
    logic          locked, accept, oor, cap, tout;

    jt51_slot_cnt #(.stages(stages)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .sync    (sync),
        .cnt_now (cnt_now),
        .locked  (locked)
    );

    assign tcnt_inc = tcnt + 1'b1;
    assign rd_ready = (state == IDLE) && !rst;
    assign rd_valid = (state == VALID);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        oor      = 1'b0;
        cap      = 1'b0;
        tout     = 1'b0;
        case (state)
            IDLE: if (req) begin
                accept = 1'b1;
                if ({1'b0, req_slot} >= (SW+1)'(stages)) begin
                    oor      = 1'b1;
                    state_nx = VALID;
                end else begin
                    state_nx = WAIT;
                end
            end
            // only cen cycles after acceptance are examined, never the acceptance cycle
            WAIT: if (cen) begin
                if (locked && cnt_now == slot) begin
                    cap      = 1'b1;
                    state_nx = VALID;
                end else if (tcnt_inc == TW'(TOUT)) begin
                    tout     = 1'b1;
                    state_nx = VALID;
                end
            end
            VALID: if (rd_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            slot    <= '0;
            tcnt    <= '0;
            rd_data <= '0;
            rd_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                slot <= req_slot;
                tcnt <= '0;
            end
            if (state == WAIT && cen && !cap) tcnt <= tcnt_inc;
            if (oor || tout) begin
                rd_data <= '0;
                rd_err  <= 1'b1;
            end
            if (cap) begin
                rd_data <= ring_dout;
                rd_err  <= 1'b0;
            end
        end
    end

endmodule
